pc_stack: RTL and testbench

Parametrised program counter with a hardware return-address stack, the next-generation PC for the gate-level CPU. It keeps sequential increment, hold and absolute jump, and adds subroutine call and return through an internal LIFO of configurable depth, with sticky fault reporting for stack misuse. It sits between the control unit, which drives the request strobes, and instruction memory, which is addressed by `pc_out`.

---
 rtl/pc_stack.sv | 108 ++++++++++
 tb/tb_pc_stack.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pc_stack.sv
// pc_stack: program counter with a hardware return-address stack and sticky fault flag.
// Optional relative branch (branch/offset ports) is enabled by defining PC_REL_BRANCH_EN.
module pc_stack #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         load,
  input  logic [WIDTH-1:0]             load_value,
  input  logic                         call,
  input  logic                         ret,
  input  logic                         fault_clr,
`ifdef PC_REL_BRANCH_EN
  input  logic                         branch,
  input  logic [WIDTH-1:0]             offset,
`endif
  output logic [WIDTH-1:0]             pc_out,
  output logic [$clog2(DEPTH+1)-1:0]   sp,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         fault
);

  localparam int SPW = $clog2(DEPTH + 1);

  // Sized to the full sp range so sp indexes it without width conversion;
  // entries at DEPTH and above are never written.
  logic [WIDTH-1:0] stack [0:(2**SPW)-1];

  logic [WIDTH-1:0] pc_next;
  logic [SPW-1:0]   sp_next;
  logic             push;
  logic             fault_set;
  logic             fault_next;

  // Priority decode of the request strobes into next PC / stack pointer / fault.
  always_comb begin
    pc_next   = pc_out;
    sp_next   = sp;
    push      = 1'b0;
    fault_set = 1'b0;
    if (call && ret) begin
      fault_set = 1'b1;
    end else if (ret) begin
      if (!stack_empty) begin
        pc_next = stack[sp - SPW'(1)];
        sp_next = sp - SPW'(1);
      end else begin
        fault_set = 1'b1;
      end
    end else if (call) begin
      if (!stack_full) begin
        push    = 1'b1;
        pc_next = load_value;
        sp_next = sp + SPW'(1);
      end else begin
        fault_set = 1'b1;
      end
    end else if (load) begin
      pc_next = load_value;
`ifdef PC_REL_BRANCH_EN
    end else if (branch) begin
      pc_next = pc_out + offset;
`endif
    end else if (enable) begin
      pc_next = pc_out + WIDTH'(1);
    end else begin
      pc_next = pc_out;
    end

    // Set wins over clear when both happen together.
    if (fault_set) begin
      fault_next = 1'b1;
    end else if (fault_clr) begin
      fault_next = 1'b0;
    end else begin
      fault_next = fault;
    end
  end

  // Architectural state; full/empty are registered decodes of the next sp.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_out      <= RESET_VEC;
      sp          <= '0;
      fault       <= 1'b0;
      stack_full  <= 1'b0;
      stack_empty <= 1'b1;
    end else begin
      pc_out      <= pc_next;
      sp          <= sp_next;
      fault       <= fault_next;
      stack_full  <= (sp_next == SPW'(DEPTH));
      stack_empty <= (sp_next == SPW'(0));
    end
  end

  // Return-address storage; deliberately not reset, a request under reset is dropped.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      stack[sp] <= pc_out + WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Randomized self-checking bench for pc_stack against a queue-based reference model.
module tb_pc_stack;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] RVEC = 8'h10;
  localparam int SPW = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             enable, load, call, ret, fault_clr;
  logic [WIDTH-1:0] load_value;
  logic             branch;
  logic [WIDTH-1:0] offset;
  logic [WIDTH-1:0] pc_out;
  logic [SPW-1:0]   sp;
  logic             stack_full, stack_empty, fault;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int m_pc;
  int m_stack[$];
  bit m_fault;

  pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VEC(RVEC)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .load       (load),
    .load_value (load_value),
    .call       (call),
    .ret        (ret),
    .fault_clr  (fault_clr),
`ifdef PC_REL_BRANCH_EN
    .branch     (branch),
    .offset     (offset),
`endif
    .pc_out     (pc_out),
    .sp         (sp),
    .stack_full (stack_full),
    .stack_empty(stack_empty),
    .fault      (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pc"},    32'(pc_out),      32'(m_pc));
    check({tag, ".sp"},    32'(sp),          32'(m_stack.size()));
    check({tag, ".full"},  32'(stack_full),  32'(m_stack.size() == DEPTH));
    check({tag, ".empty"}, 32'(stack_empty), 32'(m_stack.size() == 0));
    check({tag, ".fault"}, 32'(fault),       32'(m_fault));
  endtask

  task automatic model_reset();
    m_pc = int'(RVEC);
    m_stack.delete();
    m_fault = 1'b0;
  endtask

  // One edge of the specified behaviour, using the inputs present at that edge.
  task automatic model_step();
    bit ev;
    ev = 1'b0;
    if (call && ret) ev = 1'b1;
    else if (ret) begin
      if (m_stack.size() > 0) m_pc = m_stack.pop_back();
      else ev = 1'b1;
    end else if (call) begin
      if (m_stack.size() < DEPTH) begin
        m_stack.push_back((m_pc + 1) % 256);
        m_pc = int'(load_value);
      end else ev = 1'b1;
    end else if (load) m_pc = int'(load_value);
`ifdef PC_REL_BRANCH_EN
    else if (branch) m_pc = (m_pc + int'(offset)) % 256;
`endif
    else if (enable) m_pc = (m_pc + 1) % 256;
    if (ev) m_fault = 1'b1;
    else if (fault_clr) m_fault = 1'b0;
  endtask

  task automatic set_in(input bit c, input bit r, input bit l, input logic [7:0] lv,
                        input bit e, input bit fc);
    call = c; ret = r; load = l; load_value = lv; enable = e; fault_clr = fc;
    branch = 1'b0; offset = 8'h00;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    set_in(0, 0, 0, 8'h00, 0, 0);
    reset = 1'b1;
    #2;
    model_reset();
    check_all("reset_async");
    @(posedge clk);
    #1 reset = 1'b0;
    check_all("reset_hold");

    // Reset and increment
    set_in(0, 0, 0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) cycle("inc");

    // Increment wrap
    set_in(0, 0, 1, 8'hFF, 0, 0); cycle("load_ff");
    set_in(0, 0, 0, 8'h00, 1, 0); cycle("wrap");

    // Call then return
    set_in(0, 0, 1, 8'h20, 0, 0); cycle("load_20");
    set_in(1, 0, 0, 8'h80, 0, 0); cycle("call");
    check("call_pc", 32'(pc_out), 32'h80);
    set_in(0, 1, 0, 8'h00, 0, 0); cycle("ret");
    check("ret_pc", 32'(pc_out), 32'h21);

    // Nested calls to overflow, then clear
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1, 0, 0, 8'(8'h40 + 8'(i)), 0, 0); cycle("nest");
    end
    check("full_flag", 32'(stack_full), 32'h1);
    set_in(1, 0, 1, 8'h99, 1, 0); cycle("overflow");
    check("ovf_fault", 32'(fault), 32'h1);
    set_in(0, 0, 0, 8'h00, 0, 1); cycle("fclr");
    check("fclr_fault", 32'(fault), 32'h0);

    // Unwind, then underflow
    for (int i = 0; i < DEPTH; i++) begin
      set_in(0, 1, 0, 8'h00, 0, 0); cycle("unwind");
    end
    set_in(0, 1, 0, 8'h00, 1, 0); cycle("underflow");
    set_in(0, 0, 0, 8'h00, 0, 1); cycle("fclr2");

    // Illegal call+ret, then fault event together with clear
    set_in(1, 0, 0, 8'h30, 0, 0); cycle("call2");
    set_in(1, 1, 1, 8'h55, 1, 0); cycle("illegal");
    set_in(0, 0, 0, 8'h00, 0, 1); cycle("fclr3");
    set_in(1, 1, 0, 8'h00, 0, 1); cycle("set_wins");
    check("set_wins_fault", 32'(fault), 32'h1);

    // Call directly followed by return, from PC 0xFF
    set_in(0, 0, 1, 8'hFF, 0, 1); cycle("load_ff2");
    set_in(1, 0, 0, 8'h07, 0, 0); cycle("call_wrap");
    set_in(0, 1, 0, 8'h00, 0, 0); cycle("ret_wrap");
    check("ret_wrap_pc", 32'(pc_out), 32'h00);

`ifdef PC_REL_BRANCH_EN
    set_in(0, 0, 1, 8'h05, 0, 0); cycle("load_05");
    set_in(0, 0, 0, 8'h00, 1, 0); branch = 1'b1; offset = 8'hFE; cycle("branch");
    check("branch_pc", 32'(pc_out), 32'h03);
`endif

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      set_in($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 5) == 0, 8'($urandom_range(0, 255)),
             $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0);
`ifdef PC_REL_BRANCH_EN
      branch = ($urandom_range(0, 4) == 0);
      offset = 8'($urandom_range(0, 255));
`endif
      cycle("rand");
    end

    // Reset asserted between edges while a call is pending
    set_in(1, 0, 0, 8'hC3, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("reset_mid");
    @(posedge clk);
    #1;
    check_all("reset_mid_edge");
    reset = 1'b0;
    set_in(1, 0, 0, 8'h66, 0, 0); cycle("post_reset_call");
    set_in(0, 1, 0, 8'h00, 0, 0); cycle("post_reset_ret");
    check("post_reset_pc", 32'(pc_out), 32'(RVEC + 8'h01));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
